alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 127 ++++++++++++
 tb/tb_alu_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU (IDLE -> EXEC -> RESP); ALU_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
// Latency: accept at cycle N, rsp_valid at N+2; one operation in flight, so the issue interval is at least 3 cycles.
// Backpressure: a response held by rsp_ready=0 keeps the FSM in RESP and withholds all grants.
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [7:0]  req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic        id_q, id_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic        rsp_id_q, rsp_id_d;
    logic        grant_id;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic        ptr_q, ptr_d;

    // Favoured requester wins a tie; otherwise whoever is valid.
    always_comb begin
        grant_id = req_valid[ptr_q] ? ptr_q : ~ptr_q;
    end
`else
    always_comb begin
        grant_id = req_valid[0] ? 1'b0 : 1'b1;
    end
`endif

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        rsp_result_d = rsp_result_q;
        rsp_id_d     = rsp_id_q;
        req_ready    = 2'b00;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        ptr_d        = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[grant_id] = 1'b1;
                    a_d     = grant_id ? req_a[63:32] : req_a[31:0];
                    b_d     = grant_id ? req_b[63:32] : req_b[31:0];
                    op_d    = grant_id ? req_op[7:4]  : req_op[3:0];
                    id_d    = grant_id;
                    state_d = EXEC;
`ifdef ALU_ARB_ROUND_ROBIN_EN
                    ptr_d   = ~grant_id;
`endif
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_id_d     = id_q;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // The grant must not be visible in a cycle the register update will ignore.
        if (rst) begin
            req_ready = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            rsp_result_q <= '0;
            rsp_id_q     <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            ptr_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            rsp_result_q <= rsp_result_d;
            rsp_id_q     <= rsp_id_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            ptr_q        <= ptr_d;
`endif
        end
    end

    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the alu_* port.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [7:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result)
    );

    // Shared ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT, 8 SLTU, 9 SRA.
    always_comb begin
        case (alu_op)
            4'd0:    alu_result = alu_a + alu_b;
            4'd1:    alu_result = alu_a - alu_b;
            4'd2:    alu_result = alu_a & alu_b;
            4'd3:    alu_result = alu_a | alu_b;
            4'd4:    alu_result = alu_a ^ alu_b;
            4'd5:    alu_result = alu_a << alu_b[4:0];
            4'd6:    alu_result = alu_a >> alu_b[4:0];
            4'd7:    alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'd8:    alu_result = {31'd0, alu_a < alu_b};
            4'd9:    alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            default: alu_result = 32'd0;
        endcase
    end

    // Advance one clock; inputs are then driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
        req_a = 64'h0000_0009_0000_0008; req_b = 64'h1; req_op = 8'h00;
        tick();
        tick();
        #1;
        vec_cnt++;
        if (req_ready !== 2'b00) begin err_cnt++; $display("FAIL reset_req_ready got=%b want=00", req_ready); end
        vec_cnt++;
        if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        vec_cnt++;
        if (rsp_result !== 32'd0 || rsp_id !== 1'b0) begin
            err_cnt++; $display("FAIL reset_rsp got=%h/%b want=0/0", rsp_result, rsp_id);
        end
        vec_cnt++;
        if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 4'd0) begin
            err_cnt++; $display("FAIL reset_alu got=%h %h %h want=0 0 0", alu_a, alu_b, alu_op);
        end
        req_valid = 2'b00;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req_valid = 2'b01; req_a = {32'd0, 32'd5}; req_b = {32'd0, 32'd3}; req_op = 8'h01;
        #1;
        vec_cnt++;
        if (req_ready !== 2'b01) begin err_cnt++; $display("FAIL single_grant got=%b want=01", req_ready); end
        tick();
        req_valid = 2'b00; req_a = '1; req_b = '1; req_op = 8'hFF;
        #1;
        vec_cnt++;
        if (req_ready !== 2'b00 || rsp_valid !== 1'b0) begin
            err_cnt++; $display("FAIL single_exec got=%b/%b want=00/0", req_ready, rsp_valid);
        end
        vec_cnt++;
        if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_op !== 4'd1) begin
            err_cnt++; $display("FAIL single_alu got=%h %h %h want=5 3 1", alu_a, alu_b, alu_op);
        end
        tick();
        vec_cnt++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd2) begin
            err_cnt++; $display("FAIL single_rsp got=%b/%b/%h want=1/0/2", rsp_valid, rsp_id, rsp_result);
        end
        tick();
        vec_cnt++;
        if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL single_done got=%b want=0", rsp_valid); end
        // Idle with nothing valid must not start an operation.
        tick();
        tick();
        vec_cnt++;
        if (rsp_valid !== 1'b0 || alu_a !== 32'd5) begin
            err_cnt++; $display("FAIL idle_quiet got=%b/%h want=0/5", rsp_valid, alu_a);
        end
    endtask

    task automatic test_contention();
        logic [1:0]  exp_gnt [3];
        logic [31:0] exp_res;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01;
`else
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b01;
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        req_a = {32'h0000_00F0, 32'd1}; req_b = {32'h0000_000F, 32'd1}; req_op = {4'd4, 4'd0};
        for (int i = 0; i < 3; i++) begin
            #1;
            vec_cnt++;
            if (req_ready !== exp_gnt[i]) begin
                err_cnt++; $display("FAIL contention_grant%0d got=%b want=%b", i, req_ready, exp_gnt[i]);
            end
            exp_res = exp_gnt[i][1] ? 32'h0000_00FF : 32'd2;
            tick();
            tick();
            vec_cnt++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_gnt[i][1] || rsp_result !== exp_res) begin
                err_cnt++;
                $display("FAIL contention_rsp%0d got=%b/%b/%h want=1/%b/%h",
                         i, rsp_valid, rsp_id, rsp_result, exp_gnt[i][1], exp_res);
            end
            tick();
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_backpressure();
        req_valid = 2'b10; req_a = {32'd10, 32'd7}; req_b = {32'd20, 32'd2}; req_op = {4'd0, 4'd1};
        rsp_ready = 1'b0;
        #1;
        vec_cnt++;
        if (req_ready !== 2'b10) begin err_cnt++; $display("FAIL bp_grant got=%b want=10", req_ready); end
        tick();
        req_valid = 2'b11;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            vec_cnt++;
            if (rsp_valid !== 1'b1 || rsp_result !== 32'd30 || rsp_id !== 1'b1 || req_ready !== 2'b00) begin
                err_cnt++;
                $display("FAIL bp_hold%0d got=%b/%h/%b/%b want=1/1e/1/00",
                         i, rsp_valid, rsp_result, rsp_id, req_ready);
            end
            tick();
        end
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        tick();
        #1;
        vec_cnt++;
        if (req_ready !== 2'b01 || rsp_valid !== 1'b0) begin
            err_cnt++; $display("FAIL bp_regrant got=%b/%b want=01/0", req_ready, rsp_valid);
        end
        tick();
        req_valid = 2'b00;
        tick();
        vec_cnt++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd5) begin
            err_cnt++; $display("FAIL bp_next_rsp got=%b/%b/%h want=1/0/5", rsp_valid, rsp_id, rsp_result);
        end
        tick();
    endtask

    task automatic test_reset_exec();
        req_valid = 2'b01; req_a = {32'd1, 32'd100}; req_b = {32'd1, 32'd1}; req_op = 8'h00;
        rsp_ready = 1'b1;
        tick();
        req_valid = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        vec_cnt++;
        if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || alu_a !== 32'd0) begin
            err_cnt++; $display("FAIL rst_exec got=%b/%h/%h want=0/0/0", rsp_valid, rsp_result, alu_a);
        end
        tick();
        vec_cnt++;
        if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_exec_norsp got=%b want=0", rsp_valid); end
        // Pointer back at requester 0 after reset.
        req_valid = 2'b11;
        #1;
        vec_cnt++;
        if (req_ready !== 2'b01) begin err_cnt++; $display("FAIL rst_exec_ptr got=%b want=01", req_ready); end
        tick();
        req_valid = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_sra();
        req_valid = 2'b10; req_a = {32'h8000_0000, 32'd0}; req_b = {32'd4, 32'd0}; req_op = {4'd9, 4'd0};
        rsp_ready = 1'b1;
        #1;
        vec_cnt++;
        if (req_ready !== 2'b10) begin err_cnt++; $display("FAIL sra_grant got=%b want=10", req_ready); end
        tick();
        req_valid = 2'b00;
        tick();
        vec_cnt++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'hF800_0000) begin
            err_cnt++; $display("FAIL sra_rsp got=%b/%b/%h want=1/1/f8000000", rsp_valid, rsp_id, rsp_result);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
        req_a = '0; req_b = '0; req_op = '0;
        #1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_exec();
        test_sra();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
